// File: rtl/pipe_sched.sv
// Two-requester round-robin scheduler around a stallable 3-stage pipe computing Y = ((A+B)-(C-D))*D.
// Optional stall-cycle counter enabled by defining PIPE_SCHED_STALLCNT_EN.
module pipe_sched #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req0_c,
  input  logic [N-1:0] req0_d,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [N-1:0] req1_c,
  input  logic [N-1:0] req1_d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic         out_tag,
  output logic         busy,
  output logic [15:0]  stall_cnt
);

  logic         adv_s;
  logic         both_s;
  logic         gnt0_s;
  logic         gnt1_s;
  logic         take_s;
  logic [N-1:0] a_s, b_s, c_s, d_s;

  logic         rr_ptr_r;
  logic         v1_r, v2_r, out_valid_r;
  logic         tag1_r, tag2_r, out_tag_r;
  logic [N-1:0] sum1_r, diff1_r, d1_r;
  logic [N-1:0] x3_r, d2_r;
  logic [N-1:0] y_r;

  // Advance condition, round-robin grant, ready generation and operand select
  always_comb begin
    adv_s  = !out_valid_r | out_ready;
    both_s = req0_valid & req1_valid;
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (both_s) begin
      if (rr_ptr_r) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b1;
      end
    end else if (req0_valid) begin
      gnt0_s = 1'b1;
    end else if (req1_valid) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
    // Readies are forced low while reset is asserted, not only after the edge
    take_s     = adv_s & !flush & !rst;
    req0_ready = take_s & gnt0_s;
    req1_ready = take_s & gnt1_s;
    if (gnt1_s) begin
      a_s = req1_a;
      b_s = req1_b;
      c_s = req1_c;
      d_s = req1_d;
    end else begin
      a_s = req0_a;
      b_s = req0_b;
      c_s = req0_c;
      d_s = req0_d;
    end
  end

  // Stage valids, tags and round-robin pointer; flush drops in-flight work
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r        <= 1'b0;
      v2_r        <= 1'b0;
      out_valid_r <= 1'b0;
      tag1_r      <= 1'b0;
      tag2_r      <= 1'b0;
      out_tag_r   <= 1'b0;
      rr_ptr_r    <= 1'b0;
    end else if (flush) begin
      v1_r        <= 1'b0;
      v2_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (adv_s) begin
      v1_r        <= gnt0_s | gnt1_s;
      tag1_r      <= gnt1_s;
      v2_r        <= v1_r;
      tag2_r      <= tag1_r;
      out_valid_r <= v2_r;
      out_tag_r   <= tag2_r;
      if (both_s) begin
        rr_ptr_r <= ~rr_ptr_r;
      end
    end
  end

  // Datapath registers; they simply hold whenever the pipe is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum1_r  <= {N{1'b0}};
      diff1_r <= {N{1'b0}};
      d1_r    <= {N{1'b0}};
      x3_r    <= {N{1'b0}};
      d2_r    <= {N{1'b0}};
      y_r     <= {N{1'b0}};
    end else if (adv_s) begin
      sum1_r  <= a_s + b_s;
      diff1_r <= c_s - d_s;
      d1_r    <= d_s;
      x3_r    <= sum1_r - diff1_r;
      d2_r    <= d1_r;
      y_r     <= x3_r * d2_r;
    end
  end

`ifdef PIPE_SCHED_STALLCNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles the consumer holds back a valid result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'h0000;
`endif

  assign out_valid = out_valid_r;
  assign out_y     = y_r;
  assign out_tag   = out_tag_r;
  assign busy      = v1_r | v2_r | out_valid_r;

endmodule

// File: tb/tb_pipe_sched.sv
// Directed self-checking bench for pipe_sched: a queue-based model of in-flight operations
// is compared against the DUT every cycle, plus hand-computed literal expectations.
module tb_pipe_sched;
  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst, flush;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [N-1:0] req0_a, req0_b, req0_c, req0_d;
  logic [N-1:0] req1_a, req1_b, req1_c, req1_d;
  logic         out_valid, out_ready, out_tag, busy;
  logic [N-1:0] out_y;
  logic [15:0]  stall_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int           pos;
    logic [N-1:0] y;
    bit           tag;
  } ent_t;

  ent_t q[$];
  bit   rr_m = 1'b0;
  int   stall_m = 0;

  pipe_sched #(.N(N)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_d(req0_d),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_d(req1_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] calc(input int a, input int b, input int c, input int d);
    int r;
    r = ((a + b) - (c - d)) * d;
    return r[N-1:0];
  endfunction

  function automatic bit ov_m();
    return (q.size() > 0) && (q[0].pos == 3);
  endfunction

  function automatic bit exp_ready(input bit x);
    if (rst || flush || !(!ov_m() || out_ready)) return 1'b0;
    if (req0_valid && req1_valid) return (rr_m == x);
    return x ? req1_valid : req0_valid;
  endfunction

  function automatic int exp_stall();
`ifdef PIPE_SCHED_STALLCNT_EN
    return stall_m;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set0(input bit v, input int a, input int b, input int c, input int d);
    req0_valid = v; req0_a = a[N-1:0]; req0_b = b[N-1:0]; req0_c = c[N-1:0]; req0_d = d[N-1:0];
  endtask

  task automatic set1(input bit v, input int a, input int b, input int c, input int d);
    req1_valid = v; req1_a = a[N-1:0]; req1_b = b[N-1:0]; req1_c = c[N-1:0]; req1_d = d[N-1:0];
  endtask

  task automatic model_clear();
    q.delete();
    rr_m = 1'b0;
    stall_m = 0;
  endtask

  // Decide acceptance from the current inputs, advance one clock edge, update the model.
  task automatic tick();
    int   g;
    bit   both, adv, ov;
    ent_t e;
    g    = -1;
    both = req0_valid && req1_valid;
    ov   = ov_m();
    adv  = !ov || out_ready;
    e.pos = 1; e.y = '0; e.tag = 1'b0;
    if (!rst && !flush && adv) begin
      if (both) g = rr_m;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
    end
    if (g == 0) begin e.y = calc(req0_a, req0_b, req0_c, req0_d); e.tag = 1'b0; end
    if (g == 1) begin e.y = calc(req1_a, req1_b, req1_c, req1_d); e.tag = 1'b1; end
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (ov && !out_ready && stall_m < 65535) stall_m++;
      if (flush) begin
        q.delete();
      end else if (adv) begin
        if (ov) void'(q.pop_front());
        foreach (q[i]) q[i].pos++;
        if (g >= 0) q.push_back(e);
        if (both && g >= 0) rr_m = ~rr_m;
      end
    end
    #1;
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("req0_ready", req0_ready, exp_ready(1'b0));
    chk("req1_ready", req1_ready, exp_ready(1'b1));
    chk("out_valid", out_valid, ov_m());
    chk("busy", busy, q.size() > 0);
    chk("stall_cnt", stall_cnt, exp_stall());
    if (ov_m()) begin
      chk("out_y", out_y, q[0].y);
      chk("out_tag", out_tag, q[0].tag);
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    set0(1'b0, 0, 0, 0, 0);
    set1(1'b0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 0);
    rst = 1'b0;
    tick();

    // Single op from requester 0
    set0(1'b1, 5, 3, 4, 2);
    #1 chk("single_ready0", req0_ready, 1);
    tick();
    set0(1'b0, 0, 0, 0, 0);
    tick(); tick();
    chk("single_valid", out_valid, 1);
    chk("single_y", out_y, 12);
    chk("single_tag", out_tag, 0);
    tick(); tick();

    // Modular wrap-around from requester 1
    set1(1'b1, 1000, 100, 0, 3);
    tick();
    set1(1'b0, 0, 0, 0, 0);
    tick(); tick();
    chk("wrap_y", out_y, 237);
    chk("wrap_tag", out_tag, 1);
    tick(); tick();

    // Contention: alternating grants, back-to-back results
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        set0(1'b1, 10 * i + 1, 7, 3 * i, i + 2);
        set1(1'b1, 50 + i, 2, 9, 5);
        #1 chk("cont_grant0", req0_ready, (i % 2) == 0);
      end else begin
        set0(1'b0, 0, 0, 0, 0);
        set1(1'b0, 0, 0, 0, 0);
      end
      tick();
      if (i >= 2) begin
        chk("cont_valid", out_valid, 1);
        chk("cont_tag", out_tag, (i - 2) % 2);
      end
    end
    tick(); tick();

    // Backpressure: three ops, consumer stalls five cycles
    for (int i = 0; i < 3; i++) begin
      set0(1'b1, 20 + 10 * i, 5, i, 3);
      tick();
    end
    set0(1'b0, 0, 0, 0, 0);
    out_ready = 1'b0;
    set1(1'b1, 77, 1, 2, 3);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_y", out_y, 84);
    chk("bp_tag", out_tag, 0);
`ifdef PIPE_SCHED_STALLCNT_EN
    chk("bp_stall_cnt", stall_cnt, 5);
`else
    chk("bp_stall_cnt", stall_cnt, 0);
`endif
    out_ready = 1'b1;
    set1(1'b0, 0, 0, 0, 0);
    tick();
    chk("bp_y2", out_y, 111);
    tick();
    chk("bp_y3", out_y, 138);
    tick();
    chk("bp_drained", out_valid, 0);
    tick();

    // Flush drops two in-flight ops
    set0(1'b1, 7, 1, 2, 1);
    tick();
    set0(1'b1, 9, 9, 9, 9);
    tick();
    set0(1'b0, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", out_valid, 0);
    set1(1'b1, 1, 2, 3, 4);
    tick();
    set1(1'b0, 0, 0, 0, 0);
    tick(); tick();
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_y", out_y, 16);
    chk("post_flush_tag", out_tag, 1);
    tick();

    // Asynchronous reset with the pipe full
    for (int i = 0; i < 3; i++) begin
      set0(1'b1, i + 1, 1, 1, 1);
      tick();
    end
    set1(1'b1, 4, 4, 4, 4);
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready0", req0_ready, 0);
    chk("arst_ready1", req1_ready, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("arst_grant0", req0_ready, 1);
    chk("arst_grant1", req1_ready, 0);
    tick();
    set0(1'b0, 0, 0, 0, 0);
    set1(1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_sched.md
Name: pipe_sched

Overview:
- Two-requester scheduler and sequencer wrapped around the team's 3-stage compute pipe, Y = ((A+B)-(C-D))*D.
- Arbitrates the two operand sources round-robin and issues at most one operation per cycle.
- Tracks a valid/tag bit alongside each stage and stalls the whole pipe on output backpressure.
- Contains its own enabled copy of the 3-stage datapath so stage registers hold during stalls.

Parameters:
- N, 10, operand/result width; all arithmetic modulo 2^N, product truncated to low N bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipe flush.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a, req0_b, req0_c, req0_d  in  N each  requester 0 operands.
- req1_valid  in  1  requester 1 has operands.
- req1_ready  out  1  requester 1 operands accepted this cycle.
- req1_a, req1_b, req1_c, req1_d  in  N each  requester 1 operands.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_y  out  N  result.
- out_tag  out  1  originating requester (0/1).
- busy  out  1  any stage, S1/S2/OUT, valid.
- stall_cnt  out  16  stall-cycle counter (optional feature).

Behaviour:
- Reset (rst=1, async): all stage valids, out_valid, out_y, out_tag, busy, rr_ptr and stall_cnt = 0; req0_ready = req1_ready = 0.
- Stages and per-stage contents:
  - S1 holds A+B, C-D, D, tag, v1.
  - S2 holds X3 = S1.sum - S1.diff, D, tag, v2.
  - OUT holds X3*D (low N bits), tag, out_valid.
- adv = !out_valid | out_ready. All stage registers load only when adv=1; otherwise every stage holds. Global stall, no bubble collapsing.
- Arbitration, evaluated only when adv=1 and flush=0:
  - Only one requester valid: that requester is granted.
  - Both valid: requester rr_ptr is granted; rr_ptr then flips to the other requester.
  - rr_ptr changes only on a two-way contention grant.
  - reqX_ready = adv & !flush & granted(X). Combinational from valids, out_ready, flush and rr_ptr.
  - Transfer occurs when reqX_valid & reqX_ready. v1 loads 1 with the granted operands and tag, else v1 loads 0 (bubble).
- Latency: operands accepted at edge t → out_valid=1 after edge t+2 (3 register stages).
- Throughput: 1 result/cycle with out_ready held high.
- Output handshake: while out_valid=1 and out_ready=0, out_y and out_tag are held stable and no request is accepted.
- flush=1 at an edge: v1, v2 and out_valid clear to 0; no acceptance that cycle; rr_ptr unchanged. Data registers need not clear.
- flush and rst dominate adv; rst dominates flush.
- Reset mid-operation: all in-flight results are dropped with no output.
- busy = v1 | v2 | out_valid.
- No reordering: results exit in acceptance order.

Optional Feature:
- Macro PIPE_SCHED_STALLCNT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst only, not by flush.
- Undefined: stall_cnt is driven constant 0 and no counter register exists.

Test Plan:
- Single op, N=10: req0 A=5,B=3,C=4,D=2 with out_ready=1 → req0_ready=1 same cycle; out_valid after 3 edges, out_y=12, out_tag=0.
- Wrap-around: req1 A=1000,B=100,C=0,D=3 → out_y=237, out_tag=1.
- Contention: both requesters valid for 4 cycles, distinct operands, out_ready=1 → grants 0,1,0,1; outputs back-to-back with tags 0,1,0,1 at cycles 3–6.
- Backpressure: stream 3 ops, drop out_ready for 5 cycles after first out_valid → out_y/out_tag held, reqX_ready=0 throughout; stall_cnt=5 with macro, 0 without. After release, remaining results appear in order with none lost or duplicated.
- Flush: accept 2 ops, assert flush one cycle later → no out_valid ever for those ops; busy=0 next cycle; next op returns correct result 3 cycles after acceptance.
- Async reset: assert rst between clock edges with pipe full → out_valid, busy and readies go 0 immediately; after release, first grant to req0 under contention.
